// File: rtl/mult_8x8_seq_ctrl_if.sv
// Bundle of the requester handshake, shared 4x4 core and result signals
// used by the sequential 8x8 multiplier controller.
interface mult_8x8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_mode;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic        busy;

  // Controller side
  modport slave (
    input  in_valid, in_a, in_b, in_mode, mul_r, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_r, busy
  );

  // Requester / core / consumer side
  modport master (
    output in_valid, in_a, in_b, in_mode, mul_r, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_r, busy
  );
endinterface

// File: rtl/mult_8x8_seq_ctrl.sv
// Iterative 8x8 multiplier controller: feeds the four nibble partial products
// through one shared 4x4 core and combines them (exact ADD or approximate OR)
// in a 16-bit accumulator. One transaction in flight at a time.
module mult_8x8_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_8x8_seq_ctrl_if.slave  bus
);

  generate
    if (MUL_LAT < 0 || MUL_LAT > 3) begin : g_bad_lat
      $error("mult_8x8_seq_ctrl: MUL_LAT must be in 0..3");
    end
  endgenerate

  localparam logic [1:0] LAT = 2'(MUL_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        mode_q, mode_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [15:0] out_r_q, out_r_d;
  logic [3:0]  mul_a_q, mul_a_d;
  logic [3:0]  mul_b_q, mul_b_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  // Nibble selection: step bit 1 picks the high nibble of A, bit 0 that of B,
  // giving the order lo*lo, lo*hi, hi*lo, hi*hi.
  function automatic logic [3:0] sel_a(input logic [1:0] step, input logic [7:0] a);
    return step[1] ? a[7:4] : a[3:0];
  endfunction

  function automatic logic [3:0] sel_b(input logic [1:0] step, input logic [7:0] b);
    return step[0] ? b[7:4] : b[3:0];
  endfunction

  // Align the partial product to its nibble weight and merge it into the accumulator.
  function automatic logic [15:0] combine(input logic [15:0] acc, input logic [7:0] r,
                                          input logic [1:0] step, input logic mode);
    logic [15:0] p;
    p = {8'b0, r};
    case (step)
      2'd0:       p = p;
      2'd1, 2'd2: p = p << 4;
      default:    p = p << 8;
    endcase
    return mode ? (acc | p) : (acc + p);
  endfunction

  // Next-state logic: sequencing, accumulation and registered output values.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    step_d  = step_q;
    wcnt_d  = wcnt_q;
    out_r_d = out_r_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          mode_d  = bus.in_mode;
          acc_d   = '0;
          step_d  = '0;
          wcnt_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wcnt_q == LAT) begin
          acc_d  = combine(acc_q, bus.mul_r, step_q, mode_q);
          wcnt_d = '0;
          if (step_q == 2'd3) begin
            out_r_d = acc_d;
            state_d = ST_DONE;
          end else begin
            step_d = step_q + 2'd1;
          end
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        // The result is only visible while out_valid is high.
        if (bus.out_ready) begin
          out_r_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    // Core operands are held for the whole step and parked at zero outside RUN.
    mul_a_d     = (state_d == ST_RUN) ? sel_a(step_d, a_d) : 4'd0;
    mul_b_d     = (state_d == ST_RUN) ? sel_b(step_d, b_d) : 4'd0;
  end

  // State and registered outputs; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      step_q      <= '0;
      wcnt_q      <= '0;
      out_r_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      wcnt_q      <= wcnt_d;
      out_r_q     <= out_r_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_r     = out_r_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Bench for mult_8x8_seq_ctrl: one instance with a combinational exact core
// (MUL_LAT=0) and one with a two-stage pipelined exact core (MUL_LAT=2).
module tb_mult_8x8_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_8x8_seq_ctrl_if if0();
  mult_8x8_seq_ctrl_if if1();

  mult_8x8_seq_ctrl #(.MUL_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mult_8x8_seq_ctrl #(.MUL_LAT(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Exact 4x4 cores: combinational for dut0, two register stages for dut1
  logic [7:0] p1, p2;
  assign if0.mul_r = {4'b0, if0.mul_a} * {4'b0, if0.mul_b};
  always @(posedge clk) begin
    p1 <= {4'b0, if1.mul_a} * {4'b0, if1.mul_b};
    p2 <= p1;
  end
  assign if1.mul_r = p2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        ir;
    logic        ov;
    logic        bz;
    logic [15:0] r;
    logic [3:0]  ma;
    logic [3:0]  mb;
  } obs_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic obs_t obs(input int d);
    obs_t o;
    if (d == 0) o = '{if0.in_ready, if0.out_valid, if0.busy, if0.out_r, if0.mul_a, if0.mul_b};
    else        o = '{if1.in_ready, if1.out_valid, if1.busy, if1.out_r, if1.mul_a, if1.mul_b};
    return o;
  endfunction

  task automatic drive(input int d, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic m, input logic ordy);
    if (d == 0) begin
      if0.in_valid = v; if0.in_a = a; if0.in_b = b; if0.in_mode = m; if0.out_ready = ordy;
    end else begin
      if1.in_valid = v; if1.in_a = a; if1.in_b = b; if1.in_mode = m; if1.out_ready = ordy;
    end
  endtask

  // Reference: ADD mode is the true product; OR mode ORs the four weighted
  // nibble products (e.g. 0xFF*0xFF gives 0x00E1|0x0E10|0x0E10|0xE100 = 0xEFF1).
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic m);
    int al, ah, bl, bh;
    al = a % 16; ah = a / 16; bl = b % 16; bh = b / 16;
    if (!m) return 16'(a * b);
    return 16'((al * bl) | ((al * bh) * 16) | ((ah * bl) * 16) | ((ah * bh) * 256));
  endfunction

  // Expected {mul_a, mul_b} during step s
  function automatic logic [7:0] exp_mul(input int s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      0: return {a[3:0], b[3:0]};
      1: return {a[3:0], b[7:4]};
      2: return {a[7:4], b[3:0]};
      3: return {a[7:4], b[7:4]};
      default: return 8'h00;
    endcase
  endfunction

  // One full transaction: accept, watch the core operands per cycle, check
  // latency and result, apply 'hold' cycles of backpressure, then retire.
  task automatic txn(input int d, input logic [7:0] a, input logic [7:0] b, input logic m,
                     input int hold, input logic simul, input string tag);
    int cnt;
    int lat;
    obs_t o;
    logic [15:0] exp;
    logic [15:0] held;
    lat = lat_of(d);
    exp = ref_prod(a, b, m);
    cnt = 0;
    o = obs(d);
    while (!o.ir && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
      o = obs(d);
    end
    check({tag, ".ready"}, o.ir, 1);
    drive(d, 1'b1, a, b, m, 1'b0);
    @(posedge clk); #1;
    cnt = 0;
    while (cnt < 100) begin
      o = obs(d);
      if (o.ov) break;
      // Inputs change freely while busy; they must not affect the result.
      drive(d, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      check({tag, ".mul"}, {o.ma, o.mb}, exp_mul(cnt / (lat + 1), a, b));
      check({tag, ".runflags"}, {o.ir, o.bz}, 2'b01);
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, ".latency"}, cnt, 4 * (lat + 1));
    check({tag, ".result"}, o.r, exp);
    check({tag, ".doneflags"}, {o.ir, o.bz, o.ma, o.mb}, {2'b01, 8'h00});
    held = o.r;
    for (int h = 0; h < hold; h++) begin
      drive(d, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      @(posedge clk); #1;
      o = obs(d);
      check({tag, ".hold_r"}, o.r, held);
      check({tag, ".hold_flags"}, {o.ov, o.ir}, 2'b10);
    end
    drive(d, simul, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    @(posedge clk); #1;
    o = obs(d);
    check({tag, ".retire"}, {o.ov, o.ir, o.bz}, 3'b010);
    drive(d, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  obs_t o;

  initial begin
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      o = obs(d);
      check("reset.flags", {o.ir, o.ov, o.bz}, 3'b100);
      check("reset.out_r", o.r, 16'h0000);
      check("reset.mul", {o.ma, o.mb}, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    txn(0, 8'd200, 8'd150, 1'b0, 0, 1'b0, "add_200x150");
    check("ref_200x150", ref_prod(8'd200, 8'd150, 1'b0), 16'h7530);
    txn(0, 8'h11, 8'h11, 1'b1, 0, 1'b0, "or_11x11");
    txn(0, 8'h11, 8'h11, 1'b0, 1, 1'b0, "add_11x11");
    txn(0, 8'hFF, 8'hFF, 1'b0, 0, 1'b0, "add_ffxff");
    txn(0, 8'hFF, 8'hFF, 1'b1, 10, 1'b1, "or_ffxff_bp");
    txn(0, 8'h5A, 8'hC3, 1'b0, 0, 1'b0, "after_simul");
    txn(1, 8'd13, 8'd11, 1'b0, 0, 1'b0, "lat2_13x11");
    txn(1, 8'hFF, 8'hFF, 1'b1, 2, 1'b0, "lat2_or_ffxff");
    txn(1, 8'h00, 8'hFF, 1'b0, 0, 1'b0, "lat2_zero");

    // Randomized transactions on both instances
    for (int i = 0; i < 30; i++) begin
      txn(0, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3),
          1'($urandom), "rnd0");
      txn(1, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3),
          1'($urandom), "rnd1");
    end

    // Abort during step 2 with an asynchronous reset
    @(posedge clk); #1;
    drive(0, 1'b1, 8'hA7, 8'h5C, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    o = obs(0);
    check("abort.step2_mul", {o.ma, o.mb}, 8'hAC);
    rst_n = 1'b0;
    #1;
    o = obs(0);
    check("abort.flags", {o.ir, o.ov, o.bz}, 3'b100);
    check("abort.out_r", o.r, 16'h0000);
    check("abort.mul", {o.ma, o.mb}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    o = obs(0);
    check("abort.idle", {o.ir, o.ov, o.bz}, 3'b100);
    txn(0, 8'd3, 8'd5, 1'b0, 0, 1'b0, "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
